// File: rtl/tm1637_frame_driver.sv
// tm1637_frame_driver: native two-wire TM1637 frame sender (data cmd, digits, display control).
// Define TM1637_KEYSCAN_EN to append a key-scan read transaction with key_data/key_valid ports.
module tm1637_frame_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 250
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [8*NUM_DIGITS-1:0] digits,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    output logic                    busy,
    output logic                    done,
    output logic                    ack_err,
    output logic                    tm1637_clk,
    output logic                    tm1637_dio_oe,
`ifdef TM1637_KEYSCAN_EN
    output logic [7:0]              key_data,
    output logic                    key_valid,
`endif
    input  logic                    tm1637_dio_in
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef TM1637_KEYSCAN_EN
    localparam logic [1:0] LAST_TXN = 2'd3;
`else
    localparam logic [1:0] LAST_TXN = 2'd2;
`endif

    typedef enum logic [3:0] {IDLE, START, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_A, STOP_B, STOP_C} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]           cnt;
    logic                    tick;
    logic [2:0]              bit_idx;
    logic [2:0]              byte_cnt;
    logic [2:0]              last_byte;
    logic [1:0]              txn;
    logic                    last_txn;
    logic                    rd;
    logic [8*NUM_DIGITS-1:0] dig_q;
    logic [2:0]              br_q;
    logic                    on_q;
    logic [7:0]              dig_arr [8];
    logic [7:0]              cur_byte;
    logic [1:0]              dio_sync;

    assign tick     = busy && cnt == CW'(CLK_DIV - 1);
    assign last_txn = txn == LAST_TXN;
`ifdef TM1637_KEYSCAN_EN
    assign rd        = txn == 2'd3 && byte_cnt == 3'd1;
    assign last_byte = txn == 2'd1 ? 3'(NUM_DIGITS) : txn == 2'd3 ? 3'd1 : 3'd0;
`else
    assign rd        = 1'b0;
    assign last_byte = txn == 2'd1 ? 3'(NUM_DIGITS) : 3'd0;
`endif

    // Pad the digit snapshot to 8 entries so a 3-bit byte counter indexes it cleanly.
    for (genvar g = 0; g < 8; g++) begin : g_dig
        if (g < NUM_DIGITS) begin : g_used
            assign dig_arr[g] = dig_q[8*g +: 8];
        end else begin : g_pad
            assign dig_arr[g] = 8'h00;
        end
    end

    always_comb
        cur_byte = txn == 2'd0 ? 8'h40 :
                   txn == 2'd1 ? (byte_cnt == 3'd0 ? 8'hC0 : dig_arr[byte_cnt - 3'd1]) :
                   txn == 2'd2 ? (on_q ? {5'b10001, br_q} : 8'h80) : 8'h42;

    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n)
            dio_sync <= 2'b11;
        else
            dio_sync <= {dio_sync[0], tm1637_dio_in};

    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = START;
            START:   if (tick) state_nxt = BIT_LO;
            BIT_LO:  if (tick) state_nxt = BIT_HI;
            BIT_HI:  if (tick) state_nxt = bit_idx == 3'd7 ? ACK_LO : BIT_LO;
            ACK_LO:  if (tick) state_nxt = ACK_HI;
            ACK_HI:  if (tick) state_nxt = byte_cnt == last_byte ? STOP_A : BIT_LO;
            STOP_A:  if (tick) state_nxt = STOP_B;
            STOP_B:  if (tick) state_nxt = STOP_C;
            STOP_C:  if (tick) state_nxt = last_txn ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = state != IDLE;
        tm1637_clk    = !(state inside {BIT_LO, ACK_LO, STOP_A});
        tm1637_dio_oe = state inside {START, STOP_A, STOP_B} ||
                        (state inside {BIT_LO, BIT_HI} && !rd && !cur_byte[bit_idx]);
    end

    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            txn      <= '0;
            dig_q    <= '0;
            br_q     <= '0;
            on_q     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            cnt  <= (tick || !busy) ? '0 : cnt + 1'b1;
            done <= state == STOP_C && tick && last_txn;
            if (state == IDLE && start) begin
                dig_q   <= digits;
                br_q    <= brightness;
                on_q    <= display_on;
                ack_err <= 1'b0;
                txn     <= 2'd0;
            end
            if (tick) begin
                if (state == START) begin
                    bit_idx  <= '0;
                    byte_cnt <= '0;
                end
                if (state == BIT_HI)
                    bit_idx <= bit_idx + 1'b1;
                if (state == ACK_HI) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (!rd && dio_sync[1])
                        ack_err <= 1'b1;
                end
                if (state == STOP_C)
                    txn <= txn + 1'b1;
            end
        end

`ifdef TM1637_KEYSCAN_EN
    logic [7:0] key_sh;

    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) begin
            key_sh    <= '0;
            key_data  <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= state == STOP_C && tick && last_txn;
            if (state == BIT_HI && tick && rd)
                key_sh[bit_idx] <= dio_sync[1];
            if (state == STOP_C && tick && last_txn)
                key_data <= key_sh;
        end
`endif
endmodule

// File: tb/tb_tm1637_frame_driver.sv
// tb_tm1637_frame_driver: directed bench with a bus decoder and ACKing slave model.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_tm1637_frame_driver;
    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] digits;
    logic [2:0]  brightness;
    logic        display_on;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic        tm1637_clk;
    logic        tm1637_dio_oe;
    logic        dio;

    int          errors = 0;
    int          checks = 0;

    logic        ack_en;
    logic        mon_rst;
    logic        slave_low = 1'b0;
    logic        prev_clk = 1'b1;
    logic        prev_dio = 1'b1;
    logic [7:0]  sh = '0;
    logic [7:0]  got [$];
    int          bitcnt = 0;
    int          starts = 0;
    int          stops = 0;
    int          struct_err = 0;
    int          busy_cycles = 0;
    int          done_cnt = 0;

    always #5 clk_50M = ~clk_50M;

    assign dio = !(tm1637_dio_oe || slave_low);

    tm1637_frame_driver #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .start         (start),
        .digits        (digits),
        .brightness    (brightness),
        .display_on    (display_on),
        .busy          (busy),
        .done          (done),
        .ack_err       (ack_err),
        .tm1637_clk    (tm1637_clk),
        .tm1637_dio_oe (tm1637_dio_oe),
        .tm1637_dio_in (dio)
    );

    // Bus decoder and slave: START/STOP while CLK high, data sampled on CLK rise,
    // slave pulls DIO low across the 9th clock when ack_en is set.
    always @(negedge clk_50M) begin
        if (mon_rst) begin
            got.delete();
            bitcnt = 0;
            starts = 0;
            stops = 0;
            struct_err = 0;
            busy_cycles = 0;
            done_cnt = 0;
            slave_low = 1'b0;
            sh = '0;
        end else begin
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            if (prev_clk && tm1637_clk && prev_dio && !dio) begin
                starts++;
                bitcnt = 0;
            end else if (prev_clk && tm1637_clk && !prev_dio && dio) begin
                stops++;
                if (bitcnt % 9 != 1 || bitcnt < 10) struct_err++;
            end else if (!prev_clk && tm1637_clk) begin
                if (bitcnt % 9 < 8) begin
                    sh[bitcnt % 9] = dio;
                    if (bitcnt % 9 == 7) got.push_back(sh);
                end
                bitcnt++;
            end else if (prev_clk && !tm1637_clk) begin
                slave_low = ack_en && (bitcnt % 9 == 8);
            end
        end
        prev_clk = tm1637_clk;
        prev_dio = !(tm1637_dio_oe || slave_low);
    end

    task automatic run_frame(input logic [31:0] d, input logic [2:0] br, input logic on,
                             input logic ack, input logic poke);
        int n;
        ack_en = ack;
        digits = d;
        brightness = br;
        display_on = on;
        mon_rst = 1'b1;
        @(negedge clk_50M);
        #1 mon_rst = 1'b0;
        start = 1'b1;
        @(negedge clk_50M);
        #1 start = 1'b0;
        `CHK("busy_after_start", busy, 1'b1)
        `CHK("ack_err_cleared", ack_err, 1'b0)
        if (poke) begin
            repeat (98) @(negedge clk_50M);
            #1 start = 1'b1;
            digits = 32'h11223344;
            brightness = 3'd0;
            @(negedge clk_50M);
            #1 start = 1'b0;
        end
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk_50M);
            n++;
        end
        `CHK("done_seen", done, 1'b1)
        repeat (poke ? 700 : 10) @(negedge clk_50M);
    endtask

    task automatic check_frame(input logic [31:0] d, input logic [7:0] last, input logic exp_err);
        logic [7:0] e [7];
        e = '{8'h40, 8'hC0, d[7:0], d[15:8], d[23:16], d[31:24], last};
        `CHK("n_bytes", got.size(), 7)
        for (int i = 0; i < 7; i++)
            `CHK("byte", got[i], e[i])
        `CHK("starts", starts, 3)
        `CHK("stops", stops, 3)
        `CHK("frame_structure", struct_err, 0)
        `CHK("busy_cycles", busy_cycles, 552)
        `CHK("done_pulses", done_cnt, 1)
        `CHK("ack_err", ack_err, exp_err)
        `CHK("idle_busy", busy, 1'b0)
        `CHK("idle_clk", tm1637_clk, 1'b1)
        `CHK("idle_oe", tm1637_dio_oe, 1'b0)
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        digits = '0;
        brightness = '0;
        display_on = 1'b0;
        ack_en = 1'b1;
        mon_rst = 1'b0;
        #1;
        `CHK("rst_clk", tm1637_clk, 1'b1)
        `CHK("rst_oe", tm1637_dio_oe, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_ack_err", ack_err, 1'b0)
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);

        run_frame(32'h3F065B4F, 3'd7, 1'b1, 1'b1, 1'b0);
        check_frame(32'h3F065B4F, 8'h8F, 1'b0);

        run_frame(32'h3F065B4F, 3'd5, 1'b0, 1'b1, 1'b0);
        check_frame(32'h3F065B4F, 8'h80, 1'b0);

        run_frame(32'h3F065B4F, 3'd7, 1'b1, 1'b0, 1'b0);
        check_frame(32'h3F065B4F, 8'h8F, 1'b1);

        run_frame(32'h3F065B4F, 3'd7, 1'b1, 1'b1, 1'b0);
        check_frame(32'h3F065B4F, 8'h8F, 1'b0);

        run_frame(32'h3F065B4F, 3'd7, 1'b1, 1'b1, 1'b1);
        check_frame(32'h3F065B4F, 8'h8F, 1'b0);

        // Reset in the LOW phase of bit 3 of 0xC0 (tick 29 of the frame).
        ack_en = 1'b1;
        digits = 32'h3F065B4F;
        start = 1'b1;
        @(negedge clk_50M);
        #1 start = 1'b0;
        repeat (117) @(negedge clk_50M);
        `CHK("pre_rst_clk", tm1637_clk, 1'b0)
        `CHK("pre_rst_oe", tm1637_dio_oe, 1'b1)
        #2 rst_n = 1'b0;
        #1;
        `CHK("mid_rst_clk", tm1637_clk, 1'b1)
        `CHK("mid_rst_oe", tm1637_dio_oe, 1'b0)
        `CHK("mid_rst_busy", busy, 1'b0)
        `CHK("mid_rst_done", done, 1'b0)
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);

        run_frame(32'h01020304, 3'd2, 1'b1, 1'b1, 1'b0);
        check_frame(32'h01020304, 8'h8A, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
